// File: rtl/limb_add_seq_pkg.sv
// Shared definitions for limb-serial adder sequencers: FSM state encoding
// and a helper for sizing the limb index register.
package limb_add_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index register width; a single-limb configuration still needs one bit.
  function automatic int idx_width(input int n_limbs);
    return (n_limbs > 1) ? $clog2(n_limbs) : 1;
  endfunction

endpackage

// File: rtl/limb_add_seq_pos_add.sv
// Unsigned adder with a carry-out bit: s = x + y over W+1 bits.
module pos_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W:0]   s
);

  assign s = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/limb_add_seq.sv
// Multi-cycle wide adder: walks one LIMB-wide adder across the operands,
// least significant limb first, keeping the running carry in a register.
module limb_add_seq
  import limb_add_seq_pkg::*;
#(
  parameter int N_BITS = 32,
  parameter int LIMB   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS:0]   c,
  output logic              busy
);

  localparam int N_LIMBS = (LIMB > 0) ? (N_BITS / LIMB) : 1;
  localparam int IDX_W   = idx_width(N_LIMBS);

  if (LIMB < 1) begin : g_bad_limb
    $error("limb_add_seq: LIMB must be at least 1");
  end else if ((N_BITS % LIMB) != 0 || N_BITS < LIMB) begin : g_bad_width
    $error("limb_add_seq: N_BITS must be a non-zero multiple of LIMB");
  end

  state_t             state_q, state_d;
  logic [N_BITS-1:0]  a_q, b_q;
  logic [N_BITS:0]    c_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic               accept;
  logic               last_limb;

  logic [LIMB-1:0]    limb_a, limb_b;
  logic [LIMB:0]      sum_ab;
  logic [LIMB+1:0]    sum_full;
  logic               sum_top_unused;

  assign limb_a    = a_q[idx_q*LIMB +: LIMB];
  assign limb_b    = b_q[idx_q*LIMB +: LIMB];
  assign last_limb = (idx_q == IDX_W'(N_LIMBS - 1));
  assign accept    = in_valid && in_ready;

  // Operand limbs first, then the carry-in on a one-bit-wider adder.
  pos_add #(.W(LIMB)) u_add_ab (
    .x (limb_a),
    .y (limb_b),
    .s (sum_ab)
  );

  pos_add #(.W(LIMB + 1)) u_add_cin (
    .x (sum_ab),
    .y ({{LIMB{1'b0}}, carry_q}),
    .s (sum_full)
  );

  // Two LIMB-bit values plus a single carry bit never reach bit LIMB+1.
  assign sum_top_unused = sum_full[LIMB+1];

  assign c = c_q;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; stray encodings fall back to IDLE.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_limb) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, per-limb result write-back and carry chaining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else if (state_q == ST_RUN) begin
      c_q[idx_q*LIMB +: LIMB] <= sum_full[LIMB-1:0];
      carry_q                 <= sum_full[LIMB];
      idx_q                   <= idx_q + IDX_W'(1);
      if (last_limb) c_q[N_BITS] <= sum_full[LIMB];
    end
  end

endmodule

// File: tb/tb_limb_add_seq.sv
// Bench for limb_add_seq: directed cases, backpressure, mid-op reset,
// single-limb configuration and a random run against an a+b model.
module tb_limb_add_seq;

  localparam int NB = 32;
  localparam int LB = 8;
  localparam int NL = NB / LB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [NB-1:0] a, b;
  logic [NB:0]   c;

  logic          in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]    a8, b8;
  logic [8:0]    c8;

  int errors = 0;
  int checks = 0;

  limb_add_seq #(.N_BITS(NB), .LIMB(LB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .busy(busy)
  );

  limb_add_seq #(.N_BITS(8), .LIMB(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .c(c8), .busy(busy8)
  );

  function automatic logic [NB:0] model(input logic [NB-1:0] x, input logic [NB-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the 32-bit instance; 'full' adds per-cycle checks.
  task automatic run_op(input logic [NB-1:0] x, input logic [NB-1:0] y, input bit full);
    a = x;
    b = y;
    in_valid = 1'b1;
    if (full) check("idle_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= NL; i++) begin
      if (full) begin
        check("run_in_ready", in_ready, 0);
        check("run_out_valid", out_valid, 0);
      end
      a = $urandom;
      b = $urandom;
      tick();
    end
    check("done_out_valid", out_valid, 1);
    check("sum", c, model(x, y));
    if (full) check("done_busy", busy, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (full) begin
      check("after_out_valid", out_valid, 0);
      check("after_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] ra, rb;
    logic [NB:0]   held;

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_c", c, 0);
    check("rst8_c", c8, 0);
    rst = 1'b0;
    tick();

    // Full carry ripple through every limb.
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    // No inter-limb carries; also catches a carry left over from before.
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1);
    // Carries out of limbs 0 and 2 only.
    run_op(32'h00FF_00FF, 32'h0001_0001, 1'b1);

    // Backpressure in DONE with noise on the input side.
    a = 32'hDEAD_BEEF;
    b = 32'h2152_4111;
    held = model(a, b);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (NL) tick();
    check("bp_enter_done", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = $urandom;
      b = $urandom;
      tick();
      check("bp_c_held", c, held);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_busy", busy, 0);
    check("bp_release_in_ready", in_ready, 1);

    // Asynchronous reset two RUN edges into an operation.
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_c", c, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    check("abort_idle_out_valid", out_valid, 0);
    run_op(32'd3, 32'd4, 1'b1);

    // Single-limb configuration: result one edge after accept.
    a8 = 8'hFF;
    b8 = 8'hFF;
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    check("one_limb_accept_busy", busy8, 1);
    check("one_limb_accept_ready", in_ready8, 0);
    tick();
    check("one_limb_out_valid", out_valid8, 1);
    check("one_limb_c", c8, 9'h1FE);
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check("one_limb_release", out_valid8, 0);

    // Back-to-back random operands, biased toward all-ones limbs.
    out_ready = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1)) : 32'($urandom);
      run_op(ra, rb, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
